twiddle_mult4_stage: RTL

//  Twiddle multiplication stage of the 32-point MDC FFT, directly downstream of the 4-entry twiddle ROM.

---
 rtl/twiddle_mult4_stage.sv | 77 +++++++
 1 files changed

// File: rtl/twiddle_mult4_stage.sv
// twiddle_mult4_stage: FFT twiddle multiply stage, 2-cycle pipeline, drives 4-entry ROM index.
// Optional macro TWID_ROUND_EN selects round-half-up scaling instead of truncation.
module twiddle_mult4_stage #(
    parameter int DATA_W = 16,
    parameter int HOLD   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_r,
    input  logic signed [DATA_W-1:0] in_i,
    output logic [1:0]               rom_4_counter,
    input  logic signed [8:0]        w_r,
    input  logic signed [8:0]        w_i,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_r,
    output logic signed [DATA_W-1:0] out_i
);
    localparam int PW = DATA_W + 9;
    localparam int SW = DATA_W + 10;
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [SW-1:0] RND  = 64;

    logic [HW-1:0]        hcnt;
    logic                 v1;
    logic signed [PW-1:0] p0, p1, p2, p3;
    logic signed [SW-1:0] re, im, re_s, im_s;
    logic [DATA_W-1:0]    re_q, im_q;

    // The sample counter is split into a within-index count and the index itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt          <= '0;
            rom_4_counter <= '0;
        end else if (in_valid) begin
            hcnt          <= (hcnt == HW'(HOLD - 1)) ? '0 : hcnt + 1'b1;
            rom_4_counter <= (hcnt == HW'(HOLD - 1)) ? rom_4_counter + 2'd1 : rom_4_counter;
        end
    end

    always_ff @(posedge clk) begin
        v1 <= ~rst & in_valid;
        if (in_valid) begin
            p0 <= in_r * w_r;
            p1 <= in_i * w_i;
            p2 <= in_r * w_i;
            p3 <= in_i * w_r;
        end
    end

    always_comb begin
        re = {p0[PW-1], p0} - {p1[PW-1], p1};
        im = {p2[PW-1], p2} + {p3[PW-1], p3};
`ifdef TWID_ROUND_EN
        re_s = (re + RND) >>> 7;
        im_s = (im + RND) >>> 7;
`else
        re_s = re >>> 7;
        im_s = im >>> 7;
`endif
        re_q = re_s > MAXV ? MAXV[DATA_W-1:0] : re_s < MINV ? MINV[DATA_W-1:0] : re_s[DATA_W-1:0];
        im_q = im_s > MAXV ? MAXV[DATA_W-1:0] : im_s < MINV ? MINV[DATA_W-1:0] : im_s[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        out_valid <= ~rst & v1;
        if (rst) begin
            out_r <= '0;
            out_i <= '0;
        end else if (v1) begin
            out_r <= re_q;
            out_i <= im_q;
        end
    end
endmodule
